// File: rtl/input_conditioner.sv
// Synchronises, debounces and edge-detects the DE-board KEY/SW pins for the
// platform PIOs, with optional auto-repeat on held buttons.
module input_conditioner #(
  parameter int N_BUTTONS         = 2,
  parameter int N_SWITCHES        = 10,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int BUTTON_ACTIVE_LOW = 1,
  parameter int REPEAT_DELAY      = 25000000,
  parameter int REPEAT_PERIOD     = 5000000,
  parameter int REPEAT_EN         = 0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [N_BUTTONS-1:0]  button_raw,
  input  logic [N_SWITCHES-1:0] switch_raw,
  output logic [N_BUTTONS-1:0]  button_level,
  output logic [N_SWITCHES-1:0] switch_level,
  output logic [N_BUTTONS-1:0]  button_press,
  output logic [N_BUTTONS-1:0]  button_release,
  output logic                  switch_changed
);

  localparam int N_BITS = N_BUTTONS + N_SWITCHES;
  localparam int CW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam int R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW    = (R_MAX > 1) ? $clog2(R_MAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  logic [N_BUTTONS-1:0] btn_active;
  logic [N_BITS-1:0]    raw_all;
  logic [N_BITS-1:0]    meta_q;
  logic [N_BITS-1:0]    sync_q;
  logic [N_BITS-1:0]    stable;
  logic [N_BITS-1:0]    accept;

  logic [N_BUTTONS-1:0] press_acc;
  logic [N_BUTTONS-1:0] release_acc;
  logic [N_BUTTONS-1:0] rpt_pulse;

  logic [N_BUTTONS-1:0] press_q,   press_d;
  logic [N_BUTTONS-1:0] release_q, release_d;
  logic                 changed_q, changed_d;

  assign btn_active = (BUTTON_ACTIVE_LOW != 0) ? ~button_raw : button_raw;
  assign raw_all    = {switch_raw, btn_active};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw_all;
      sync_q <= meta_q;
    end
  end

  // Each bit owns its counter; any return to the stable level discards the run.
  for (genvar i = 0; i < N_BITS; i++) begin : g_deb
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          hit;

    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      hit      = 1'b0;
      if (sync_q[i] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[i];
        cnt_d    = '0;
        hit      = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable[i] = stable_q;
    assign accept[i] = hit;
  end

  assign press_acc   = accept[N_BUTTONS-1:0] &  sync_q[N_BUTTONS-1:0];
  assign release_acc = accept[N_BUTTONS-1:0] & ~sync_q[N_BUTTONS-1:0];

  // An accepted release wins over a repeat that would land on the same edge.
  for (genvar b = 0; b < N_BUTTONS; b++) begin : g_rpt
    rpt_state_e    state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic          pulse;

    always_comb begin
      state_d = state_q;
      r_d     = r_q;
      pulse   = 1'b0;
      case (state_q)
        RPT_IDLE: begin
          if (press_acc[b]) begin
            state_d = RPT_DELAY;
            r_d     = '0;
          end
        end
        RPT_DELAY: begin
          if (release_acc[b]) begin
            state_d = RPT_IDLE;
            r_d     = '0;
          end else if (r_q == DELAY_LAST) begin
            state_d = RPT_REPEAT;
            r_d     = '0;
            pulse   = 1'b1;
          end else begin
            r_d = r_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (release_acc[b]) begin
            state_d = RPT_IDLE;
            r_d     = '0;
          end else if (r_q == PERIOD_LAST) begin
            r_d   = '0;
            pulse = 1'b1;
          end else begin
            r_d = r_q + 1'b1;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          r_d     = '0;
        end
      endcase
      if (REPEAT_EN == 0) begin
        state_d = RPT_IDLE;
        r_d     = '0;
        pulse   = 1'b0;
      end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        state_q <= RPT_IDLE;
        r_q     <= '0;
      end else begin
        state_q <= state_d;
        r_q     <= r_d;
      end
    end

    assign rpt_pulse[b] = pulse;
  end

  always_comb begin
    press_d   = press_acc | rpt_pulse;
    release_d = release_acc;
    changed_d = |accept[N_BITS-1:N_BUTTONS];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      press_q   <= '0;
      release_q <= '0;
      changed_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      changed_q <= changed_d;
    end
  end

  assign button_level   = stable[N_BUTTONS-1:0];
  assign switch_level   = stable[N_BITS-1:N_BUTTONS];
  assign button_press   = press_q;
  assign button_release = release_q;
  assign switch_changed = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expected output frames are queued
// per edge from the documented latencies and popped as the DUT advances.
module tb_input_conditioner;

  localparam int DEB  = 4;
  localparam int RDLY = 6;
  localparam int RPER = 3;
  localparam int LAT  = DEB + 2;

  logic       clk = 1'b0;
  logic       rstN;
  logic [1:0] buttonRaw;
  logic [9:0] switchRaw;
  logic [1:0] buttonLevel, buttonPress, buttonRelease;
  logic [9:0] switchLevel;
  logic       switchChanged;

  logic [1:0] repButtonRaw;
  logic [9:0] repSwitchRaw;
  logic [1:0] repButtonLevel, repButtonPress, repButtonRelease;
  logic [9:0] repSwitchLevel;
  logic       repSwitchChanged;

  typedef struct packed {
    logic [1:0] bl;
    logic [1:0] bp;
    logic [1:0] br;
    logic [9:0] sl;
    logic       sc;
  } obs_t;

  obs_t       expQ[$];
  logic [5:0] repQ[$];
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .N_BUTTONS(2), .N_SWITCHES(10), .DEBOUNCE_CYCLES(DEB), .BUTTON_ACTIVE_LOW(1),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER), .REPEAT_EN(0)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rstN), .button_raw(buttonRaw), .switch_raw(switchRaw),
    .button_level(buttonLevel), .switch_level(switchLevel), .button_press(buttonPress),
    .button_release(buttonRelease), .switch_changed(switchChanged)
  );

  input_conditioner #(
    .N_BUTTONS(2), .N_SWITCHES(10), .DEBOUNCE_CYCLES(DEB), .BUTTON_ACTIVE_LOW(1),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER), .REPEAT_EN(1)
  ) dutRep (
    .clk_clk(clk), .reset_reset_n(rstN), .button_raw(repButtonRaw), .switch_raw(repSwitchRaw),
    .button_level(repButtonLevel), .switch_level(repSwitchLevel), .button_press(repButtonPress),
    .button_release(repButtonRelease), .switch_changed(repSwitchChanged)
  );

  function automatic obs_t sampleMain();
    obs_t o;
    o.bl = buttonLevel;
    o.bp = buttonPress;
    o.br = buttonRelease;
    o.sl = switchLevel;
    o.sc = switchChanged;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t e, o;
    o = sampleMain();
    checks++;
    if (o !== '0) $display("[TB] FAIL reset_hold: got %h expected %h", o, 17'h0);
    else passes++;
    rstN = 1'b1;
    for (int k = 1; k <= 4; k++) expQ.push_back('0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = expQ.pop_front();
      o = sampleMain();
      checks++;
      if (o !== e) $display("[TB] FAIL reset_idle edge %0d: got %h expected %h", k, o, e);
      else passes++;
    end
  endtask

  task automatic test_clean_press();
    obs_t e, o;
    for (int k = 1; k <= 24; k++) begin
      e = '0;
      e.bl[0] = (k >= LAT) && (k < 16 + LAT);
      e.bp[0] = (k == LAT);
      e.br[0] = (k == 16 + LAT);
      expQ.push_back(e);
    end
    for (int k = 1; k <= 24; k++) begin
      if (k == 1)  buttonRaw[0] = 1'b0;
      if (k == 17) buttonRaw[0] = 1'b1;
      tick();
      e = expQ.pop_front();
      o = sampleMain();
      checks++;
      if (o !== e) $display("[TB] FAIL clean_press edge %0d: got %h expected %h", k, o, e);
      else passes++;
    end
  endtask

  task automatic test_bounce();
    obs_t e, o;
    bit pressed;
    for (int k = 1; k <= 30; k++) begin
      e = '0;
      e.bl[1] = (k >= 8 + LAT) && (k < 19 + LAT);
      e.bp[1] = (k == 8 + LAT);
      e.br[1] = (k == 19 + LAT);
      expQ.push_back(e);
    end
    for (int k = 1; k <= 30; k++) begin
      pressed = (k < 20) && ((k >= 9) || ((((k - 1) / 2) % 2) == 0));
      buttonRaw[1] = ~pressed;
      tick();
      e = expQ.pop_front();
      o = sampleMain();
      checks++;
      if (o !== e) $display("[TB] FAIL bounce edge %0d: got %h expected %h", k, o, e);
      else passes++;
    end
  endtask

  task automatic test_switch_group();
    obs_t e, o;
    for (int k = 1; k <= 20; k++) begin
      e = '0;
      e.sl = ((k >= LAT) && (k < 10 + LAT)) ? 10'h201 : 10'h000;
      e.sc = (k == LAT) || (k == 10 + LAT);
      expQ.push_back(e);
    end
    for (int k = 1; k <= 20; k++) begin
      if (k == 1)  switchRaw = 10'h201;
      if (k == 11) switchRaw = 10'h000;
      tick();
      e = expQ.pop_front();
      o = sampleMain();
      checks++;
      if (o !== e) $display("[TB] FAIL switch_group edge %0d: got %h expected %h", k, o, e);
      else passes++;
    end
  endtask

  task automatic test_simultaneous();
    obs_t e, o;
    for (int k = 1; k <= 16; k++) begin
      e = '0;
      e.bl = ((k >= LAT) && (k < 8 + LAT)) ? 2'b11 : 2'b00;
      e.sl = ((k >= LAT) && (k < 8 + LAT)) ? 10'h0FF : 10'h000;
      e.bp = (k == LAT) ? 2'b11 : 2'b00;
      e.br = (k == 8 + LAT) ? 2'b11 : 2'b00;
      e.sc = (k == LAT) || (k == 8 + LAT);
      expQ.push_back(e);
    end
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) begin
        buttonRaw = 2'b00;
        switchRaw = 10'h0FF;
      end
      if (k == 9) begin
        buttonRaw = 2'b11;
        switchRaw = 10'h000;
      end
      tick();
      e = expQ.pop_front();
      o = sampleMain();
      checks++;
      if (o !== e) $display("[TB] FAIL simultaneous edge %0d: got %h expected %h", k, o, e);
      else passes++;
    end
  endtask

  task automatic test_auto_repeat();
    logic [5:0] e, o;
    int relK, relAcc;
    bit lvl, prs;
    for (int phase = 0; phase < 2; phase++) begin
      relK   = (phase == 0) ? 21 : 22;
      relAcc = relK + LAT - 1;
      for (int k = 1; k <= 32; k++) begin
        lvl = (k >= LAT) && (k < relAcc);
        prs = (k == LAT) ||
              ((k >= LAT + RDLY) && (k < relAcc) && (((k - LAT - RDLY) % RPER) == 0));
        e = {1'b0, lvl, 1'b0, prs, 1'b0, (k == relAcc)};
        repQ.push_back(e);
      end
      for (int k = 1; k <= 32; k++) begin
        if (k == 1)    repButtonRaw[0] = 1'b0;
        if (k == relK) repButtonRaw[0] = 1'b1;
        tick();
        e = repQ.pop_front();
        o = {repButtonLevel, repButtonPress, repButtonRelease};
        checks++;
        if (o !== e)
          $display("[TB] FAIL auto_repeat rel%0d edge %0d: got %b expected %b", relK, k, o, e);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid_count();
    obs_t e, o;
    for (int k = 1; k <= 8; k++) begin
      e = '0;
      e.sl = (k >= LAT) ? 10'h3FF : 10'h000;
      e.sc = (k == LAT);
      expQ.push_back(e);
    end
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) switchRaw = 10'h3FF;
      tick();
      e = expQ.pop_front();
      o = sampleMain();
      checks++;
      if (o !== e) $display("[TB] FAIL reset_mid_setup edge %0d: got %h expected %h", k, o, e);
      else passes++;
    end
    buttonRaw[0] = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      e = '0;
      e.sl = 10'h3FF;
      expQ.push_back(e);
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      e = expQ.pop_front();
      o = sampleMain();
      checks++;
      if (o !== e) $display("[TB] FAIL reset_mid_press edge %0d: got %h expected %h", k, o, e);
      else passes++;
    end
    rstN = 1'b0;
    #1;
    o = sampleMain();
    checks++;
    if (o !== '0) $display("[TB] FAIL reset_mid_async: got %h expected %h", o, 17'h0);
    else passes++;
    for (int k = 1; k <= 2; k++) begin
      tick();
      o = sampleMain();
      checks++;
      if (o !== '0) $display("[TB] FAIL reset_mid_held cycle %0d: got %h expected %h", k, o, 17'h0);
      else passes++;
    end
    rstN = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      e = '0;
      e.bl[0] = (k >= LAT);
      e.bp[0] = (k == LAT);
      e.sl    = (k >= LAT) ? 10'h3FF : 10'h000;
      e.sc    = (k == LAT);
      expQ.push_back(e);
    end
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      e = expQ.pop_front();
      o = sampleMain();
      checks++;
      if (o !== e) $display("[TB] FAIL reset_mid_restart edge %0d: got %h expected %h", k, o, e);
      else passes++;
    end
  endtask

  initial begin
    rstN         = 1'b0;
    buttonRaw    = 2'b11;
    switchRaw    = 10'h000;
    repButtonRaw = 2'b11;
    repSwitchRaw = 10'h000;
    tick();
    tick();
    $display("[TB] starting input_conditioner tests");
    test_reset();
    test_clean_press();
    test_bounce();
    test_switch_group();
    test_simultaneous();
    test_auto_repeat();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
